// File: rtl/fetch_pkg.sv
// Shared constants for the fetch-stage PC sequencer: state encodings, default
// reset address, NOP encoding and the word-alignment mask.
package fetch_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] DELIVER = 2'd2;
    localparam logic [1:0] KILL    = 2'd3;

    localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK     = 32'hFFFF_FFFC;

    // Force an address onto a word boundary
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select for the fetch stage. Priority: trap > branch > pc+4 > hold.
// redirect_o flags that a trap or branch target was chosen.
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        advance_i,
    input  logic        trap_i,
    input  logic [31:0] trap_vec_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] next_pc_o,
    output logic        redirect_o
);

    // Priority mux; pc+4 wraps naturally modulo 2^32
    always_comb begin
        next_pc_o  = pc_i;
        redirect_o = 1'b0;
        if (trap_i) begin
            next_pc_o  = align_pc(trap_vec_i);
            redirect_o = 1'b1;
        end else if (br_taken_i) begin
            next_pc_o  = align_pc(br_target_i);
            redirect_o = 1'b1;
        end else if (advance_i) begin
            next_pc_o = pc_i + 32'd4;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: holds the fetch PC, issues one instruction-port
// request per instruction, hands the fetched word to decode under a
// valid/stall handshake and drops fetches made stale by a redirect.
// Optional trap redirect port enabled by defining PC_FETCH_TRAP_EN.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic        iport_cyc_o,
    output logic [31:0] iport_addr_o,
    input  logic        iport_ack_i,
    input  logic [31:0] iport_dat_i,
`ifdef PC_FETCH_TRAP_EN
    input  logic        trap_i,
    input  logic [31:0] trap_vec_i,
`endif
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;

    logic        trap_w;
    logic [31:0] trap_vec_w;
    logic        advance_w;
    logic        redirect_w;

`ifdef PC_FETCH_TRAP_EN
    assign trap_w     = trap_i;
    assign trap_vec_w = trap_vec_i;
`else
    assign trap_w     = 1'b0;
    assign trap_vec_w = 32'h0000_0000;
`endif

    // PC only advances when decode consumes the held instruction
    assign advance_w = (state_q == DELIVER) && !stall_i;

    pc_next_sel u_pc_next_sel (
        .pc_i        (pc_q),
        .advance_i   (advance_w),
        .trap_i      (trap_w),
        .trap_vec_i  (trap_vec_w),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .next_pc_o   (pc_d),
        .redirect_o  (redirect_w)
    );

    // Next-state logic for the fetch FSM and the delivered-instruction register
    always_comb begin
        state_d     = state_q;
        kill_addr_d = kill_addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect_w) begin
                    // With ack the bus is free, so re-request the target straight away;
                    // without ack the stale cycle must be allowed to finish in KILL.
                    if (!iport_ack_i) begin
                        kill_addr_d = pc_q;
                        state_d     = KILL;
                    end
                end else if (iport_ack_i) begin
                    instr_d    = iport_dat_i;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = DELIVER;
                end
            end
            DELIVER: begin
                if (redirect_w || !stall_i) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            KILL: begin
                // Stale data is dropped; pc_q already tracks any further redirect
                if (iport_ack_i) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= align_pc(RESET_ADDR);
            kill_addr_q <= align_pc(RESET_ADDR);
            instr_q     <= NOP_INSTR;
            instr_pc_q  <= align_pc(RESET_ADDR);
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
        end
    end

    // Bus and decode-side outputs
    always_comb begin
        iport_cyc_o   = (state_q == REQ) || (state_q == KILL);
        iport_addr_o  = (state_q == KILL) ? kill_addr_q : pc_q;
        pc_o          = pc_q;
        instr_valid_o = valid_q;
        instr_o       = valid_q ? instr_q : NOP_INSTR;
        instr_pc_o    = instr_pc_q;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed vector table, hand-written
// redirect/wrap/reset sequences and a randomized run against a
// transaction-level reference model. Trap checks appear with PC_FETCH_TRAP_EN.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, br, ack, trap;
    logic [31:0] tgt, dat, vec;
    logic        cyc, valid;
    logic [31:0] addr, pc, instr, ipc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .br_taken_i    (br),
        .br_target_i   (tgt),
        .iport_cyc_o   (cyc),
        .iport_addr_o  (addr),
        .iport_ack_i   (ack),
        .iport_dat_i   (dat),
`ifdef PC_FETCH_TRAP_EN
        .trap_i        (trap),
        .trap_vec_i    (vec),
`endif
        .pc_o          (pc),
        .instr_o       (instr),
        .instr_pc_o    (ipc),
        .instr_valid_o (valid)
    );

    // Reference model: tracks whether we are in the post-reset bubble, whether a
    // word is held for decode, and whether an outstanding bus cycle is stale.
    bit          m_boot, m_have, m_stale;
    logic [31:0] m_pc, m_instr, m_ipc, m_saddr;

    task automatic model_reset();
        m_boot  = 1'b1;
        m_have  = 1'b0;
        m_stale = 1'b0;
        m_pc    = 32'h0;
        m_ipc   = 32'h0;
        m_instr = NOP;
        m_saddr = 32'h0;
    endtask

    function automatic logic [159:0] model_bundle();
        logic        e_cyc;
        logic [31:0] e_addr;
        e_cyc  = !m_boot && !m_have;
        e_addr = m_stale ? m_saddr : m_pc;
        return {30'b0, e_cyc, e_addr, m_pc, m_have, (m_have ? m_instr : NOP), m_ipc};
    endfunction

    function automatic logic [159:0] dut_bundle();
        return {30'b0, cyc, addr, pc, valid, instr, ipc};
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic model_tick();
        bit          redir;
        logic [31:0] dest;
        bit          t;
`ifdef PC_FETCH_TRAP_EN
        t = trap;
`else
        t = 1'b0;
`endif
        redir = t || br;
        dest  = (t ? vec : tgt) & 32'hFFFF_FFFC;
        if (m_boot) begin
            m_boot = 1'b0;
            if (redir) m_pc = dest;
        end else if (m_have) begin
            if (redir) begin
                m_have = 1'b0;
                m_pc   = dest;
            end else if (!stall) begin
                m_have = 1'b0;
                m_pc   = m_pc + 32'd4;
            end
        end else if (m_stale) begin
            if (ack) m_stale = 1'b0;
            if (redir) m_pc = dest;
        end else begin
            if (redir) begin
                if (!ack) begin
                    m_stale = 1'b1;
                    m_saddr = m_pc;
                end
                m_pc = dest;
            end else if (ack) begin
                m_have  = 1'b1;
                m_instr = dat;
                m_ipc   = m_pc;
            end
        end
    endtask

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic a,
                         input logic [31:0] d, input logic tr, input logic [31:0] v);
        stall = s;
        br    = b;
        tgt   = t;
        ack   = a;
        dat   = d;
        trap  = tr;
        vec   = v;
    endtask

    // Drive, settle, compare against model; caller may add explicit checks before advance
    task automatic apply(input logic s, input logic b, input logic [31:0] t, input logic a,
                         input logic [31:0] d);
        drive(s, b, t, a, d, 1'b0, 32'h0);
        #1;
        chk("model", dut_bundle(), model_bundle());
    endtask

    task automatic advance();
        model_tick();
        @(negedge clk);
    endtask

    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic a,
                        input logic [31:0] d);
        apply(s, b, t, a, d);
        advance();
    endtask

    // Asserts reset between edges, checks the immediate effect, releases at next negedge
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();
        #1;
        chk("reset_model", dut_bundle(), model_bundle());
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        ack;
        logic [31:0] dat;
        logic        e_cyc;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic a, input logic [31:0] d,
                                input logic c, input logic [31:0] ad, input logic [31:0] p,
                                input logic v, input logic [31:0] i, input logic [31:0] ip);
        vec_t r;
        r.stall = s; r.ack = a; r.dat = d;
        r.e_cyc = c; r.e_addr = ad; r.e_pc = p; r.e_valid = v; r.e_instr = i; r.e_ipc = ip;
        return r;
    endfunction

    vec_t tbl[17];

    initial begin
        // 0-wait fetches at 0,4,8,12,16 then a 5-cycle stall and resume at 20
        tbl[0] = mk(0, 0, 32'h0,         0, 32'd0,  32'd0,  0, NOP,           32'd0);
        tbl[1] = mk(0, 1, 32'hAAAA_0001, 1, 32'd0,  32'd0,  0, NOP,           32'd0);
        tbl[2] = mk(0, 0, 32'h0,         0, 32'd0,  32'd0,  1, 32'hAAAA_0001, 32'd0);
        tbl[3] = mk(0, 1, 32'hAAAA_0002, 1, 32'd4,  32'd4,  0, NOP,           32'd0);
        tbl[4] = mk(0, 0, 32'h0,         0, 32'd4,  32'd4,  1, 32'hAAAA_0002, 32'd4);
        tbl[5] = mk(0, 1, 32'hAAAA_0003, 1, 32'd8,  32'd8,  0, NOP,           32'd4);
        tbl[6] = mk(0, 0, 32'h0,         0, 32'd8,  32'd8,  1, 32'hAAAA_0003, 32'd8);
        tbl[7] = mk(0, 1, 32'hAAAA_0004, 1, 32'd12, 32'd12, 0, NOP,           32'd8);
        tbl[8] = mk(0, 0, 32'h0,         0, 32'd12, 32'd12, 1, 32'hAAAA_0004, 32'd12);
        tbl[9] = mk(0, 1, 32'hAAAA_0005, 1, 32'd16, 32'd16, 0, NOP,           32'd12);
        for (int i = 10; i < 15; i++)
            tbl[i] = mk(1, 0, 32'h0, 0, 32'd16, 32'd16, 1, 32'hAAAA_0005, 32'd16);
        tbl[15] = mk(0, 0, 32'h0,        0, 32'd16, 32'd16, 1, 32'hAAAA_0005, 32'd16);
        tbl[16] = mk(0, 0, 32'h0,        1, 32'd20, 32'd20, 0, NOP,           32'd16);

        // Reset state
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();
        #1;
        chk("reset_cyc",   {159'b0, cyc},   {159'b0, 1'b0});
        chk("reset_pc",    {128'b0, pc},    {128'b0, 32'h0});
        chk("reset_valid", {159'b0, valid}, {159'b0, 1'b0});
        chk("reset_instr", {128'b0, instr}, {128'b0, NOP});
        chk("reset_ipc",   {128'b0, ipc},   {128'b0, 32'h0});
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].stall, 1'b0, 32'h0, tbl[i].ack, tbl[i].dat, 1'b0, 32'h0);
            #1;
            chk($sformatf("vec[%0d]", i), dut_bundle(),
                {30'b0, tbl[i].e_cyc, tbl[i].e_addr, tbl[i].e_pc, tbl[i].e_valid,
                 tbl[i].e_instr, tbl[i].e_ipc});
            chk("model", dut_bundle(), model_bundle());
            advance();
        end

        // Redirect during a waited REQ at 0x8 -> KILL, stale data never delivered
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h1111_0000);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h1111_0004);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        apply(0, 1, 32'h0000_1003, 0, 0);
        advance();
        apply(0, 0, 0, 0, 0);
        chk("kill_addr", {128'b0, addr}, {128'b0, 32'h8});
        chk("kill_pc",   {128'b0, pc},   {128'b0, 32'h1000});
        advance();
        apply(0, 0, 0, 1, 32'hDEAD_BEEF);
        advance();
        apply(0, 0, 0, 0, 0);
        chk("after_kill_addr", {127'b0, cyc, addr}, {127'b0, 1'b1, 32'h1000});
        chk("after_kill_valid", {159'b0, valid}, {159'b0, 1'b0});
        advance();

        // Redirect together with ack: data dropped, target requested next cycle
        apply(0, 1, 32'h0000_2000, 1, 32'h1234_5678);
        advance();
        apply(0, 0, 0, 0, 0);
        chk("redir_ack_addr",  {127'b0, cyc, addr}, {127'b0, 1'b1, 32'h2000});
        chk("redir_ack_valid", {159'b0, valid},     {159'b0, 1'b0});
        advance();

        // Wrap from 0xFFFF_FFFC to 0
        step(0, 1, 32'hFFFF_FFFF, 1, 0);
        apply(0, 0, 0, 1, 32'hCAFE_0001);
        chk("top_addr", {128'b0, addr}, {128'b0, 32'hFFFF_FFFC});
        advance();
        apply(0, 0, 0, 0, 0);
        chk("top_ipc", {128'b0, ipc}, {128'b0, 32'hFFFF_FFFC});
        advance();
        apply(0, 0, 0, 0, 0);
        chk("wrap_addr", {127'b0, cyc, addr}, {127'b0, 1'b1, 32'h0});
        advance();
        step(0, 0, 0, 1, 32'hCAFE_0002);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Reset in the middle of a REQ at 0x4: bus cycle dropped without a clock edge
        rst = 1'b1;
        #1;
        chk("midreq_rst_cyc", {159'b0, cyc}, {159'b0, 1'b0});
        chk("midreq_rst_pc",  {128'b0, pc},  {128'b0, 32'h0});
        do_reset();

`ifdef PC_FETCH_TRAP_EN
        // Trap outranks a simultaneous branch
        step(0, 0, 0, 0, 0);
        drive(0, 1, 32'h0000_0200, 0, 0, 1, 32'h0000_0100);
        #1;
        chk("model", dut_bundle(), model_bundle());
        advance();
        step(0, 0, 0, 1, 32'h5555_5555);
        apply(0, 0, 0, 0, 0);
        chk("trap_prio_addr", {128'b0, addr}, {128'b0, 32'h0000_0100});
        advance();
`endif

        // Randomized run against the reference model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), $urandom,
                      $urandom_range(0, 1) == 1, $urandom,
                      ($urandom_range(0, 15) == 0), $urandom);
                #1;
                chk("random", dut_bundle(), model_bundle());
                advance();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
